// File: rtl/eth_pkg.sv
// Shared definitions for the packet capture path: write FSM encoding and
// default parameter values.
package eth_pkg;

    localparam int DEF_DEPTH_LOG2 = 12;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DROP
    } wr_state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port storage for the capture buffer: one write port and one
// registered read port with enable. The read register holds between reads.
module capture_ram #(
    parameter int ADDR_W = 12,
    parameter int WIDTH  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/pkt_capture_buf.sv
// Packet capture buffer: stores whole packets, exposes only committed ones to
// the reader, drops bad or oversized packets and counts both outcomes.
module pkt_capture_buf
    import eth_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    input  logic                in_eop,
    input  logic                in_err,
    input  logic                rd_req,
    output logic [DATA_W:0]     rd_data,
    output logic                rd_valid,
    output logic                rd_empty,
    output logic [DEPTH_LOG2:0] level,
    output logic [CNT_W-1:0]    pkt_count,
    output logic [CNT_W-1:0]    drop_count
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0]    DEPTH_P = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    wr_state_e        state_q, state_d;
    logic [PW-1:0]    wr_q, wr_d, cm_q, cm_d, rd_q, rd_d;
    logic [CNT_W-1:0] pkt_q, pkt_d, drop_q, drop_d;
    logic             flush_q, flush_d;
    logic             rd_valid_q;
    logic             full, rd_fire, we, pkt_inc, drop_inc;

    // Occupancy counts uncommitted beats too, against the registered read pointer.
    assign full     = (wr_q - rd_q) == DEPTH_P;
    assign rd_empty = (rd_q == cm_q);
    assign rd_fire  = rd_req && !rd_empty && !clear;
    assign level    = cm_q - rd_q;
    assign rd_valid = rd_valid_q;
    assign pkt_count  = pkt_q;
    assign drop_count = drop_q;

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        cm_d     = cm_q;
        flush_d  = flush_q;
        we       = 1'b0;
        pkt_inc  = 1'b0;
        drop_inc = 1'b0;

        if (flush_q) begin
            // Tail of a packet abandoned by clear: swallow silently up to eop.
            if (in_valid && in_eop) flush_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACTIVE: begin
                    if (in_valid) begin
                        if (full) begin
                            wr_d = cm_q;
                            if (in_eop) begin
                                drop_inc = 1'b1;
                                state_d  = IDLE;
                            end else begin
                                state_d  = DROP;
                            end
                        end else begin
                            we   = 1'b1;
                            wr_d = wr_q + 1'b1;
                            if (in_eop) begin
                                state_d = IDLE;
                                if (in_err) begin
                                    wr_d     = cm_q;
                                    drop_inc = 1'b1;
                                end else begin
                                    cm_d    = wr_q + 1'b1;
                                    pkt_inc = 1'b1;
                                end
                            end else begin
                                state_d = ACTIVE;
                            end
                        end
                    end
                end
                DROP: begin
                    if (in_valid && in_eop) begin
                        drop_inc = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        rd_d   = rd_fire ? rd_q + 1'b1 : rd_q;
        pkt_d  = (pkt_inc  && pkt_q  != CNT_MAX) ? pkt_q  + 1'b1 : pkt_q;
        drop_d = (drop_inc && drop_q != CNT_MAX) ? drop_q + 1'b1 : drop_q;

        if (clear) begin
            state_d = IDLE;
            wr_d    = '0;
            cm_d    = '0;
            rd_d    = '0;
            pkt_d   = '0;
            drop_d  = '0;
            we      = 1'b0;
            // A packet still open after this cycle must be discarded to its eop.
            flush_d = (flush_q || state_q != IDLE || in_valid) && !(in_valid && in_eop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_q       <= '0;
            cm_q       <= '0;
            rd_q       <= '0;
            pkt_q      <= '0;
            drop_q     <= '0;
            flush_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            cm_q       <= cm_d;
            rd_q       <= rd_d;
            pkt_q      <= pkt_d;
            drop_q     <= drop_d;
            flush_q    <= flush_d;
            rd_valid_q <= rd_fire;
        end
    end

    capture_ram #(
        .ADDR_W (DEPTH_LOG2),
        .WIDTH  (DATA_W + 1)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (wr_q[DEPTH_LOG2-1:0]),
        .wdata ({in_eop, in_data}),
        .re    (rd_fire),
        .raddr (rd_q[DEPTH_LOG2-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_pkt_capture_buf.sv
// Directed bench for pkt_capture_buf: a large default-depth instance, a
// 16-entry instance and a 16-entry instance with 3-bit counters share stimulus.
module tb_pkt_capture_buf;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0, in_eop = 1'b0, in_err = 1'b0, rd_req = 1'b0;

    logic [8:0]  a_rd_data, b_rd_data, c_rd_data;
    logic        a_rd_valid, b_rd_valid, c_rd_valid;
    logic        a_rd_empty, b_rd_empty, c_rd_empty;
    logic [12:0] a_level;
    logic [4:0]  b_level, c_level;
    logic [15:0] a_pkt, a_drop, b_pkt, b_drop;
    logic [2:0]  c_pkt, c_drop;

    pkt_capture_buf dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_eop(in_eop), .in_err(in_err), .rd_req(rd_req), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .rd_empty(a_rd_empty), .level(a_level),
        .pkt_count(a_pkt), .drop_count(a_drop));

    pkt_capture_buf #(.DEPTH_LOG2(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_eop(in_eop), .in_err(in_err), .rd_req(rd_req), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .rd_empty(b_rd_empty), .level(b_level),
        .pkt_count(b_pkt), .drop_count(b_drop));

    pkt_capture_buf #(.DEPTH_LOG2(4), .CNT_W(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_eop(in_eop), .in_err(in_err), .rd_req(rd_req), .rd_data(c_rd_data),
        .rd_valid(c_rd_valid), .rd_empty(c_rd_empty), .level(c_level),
        .pkt_count(c_pkt), .drop_count(c_drop));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v, eop, err;
        logic [7:0]  d;
        logic        rd;
        logic        rv;
        logic [8:0]  rdat;
        logic [4:0]  lvl;
        logic        emp;
        logic [15:0] pkt, drop;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_eop = 1'b0; in_err = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic send_pkt(input int len, input int base, input bit err, input bit eop_last);
        for (int j = 0; j < len; j++) begin
            in_valid = 1'b1;
            in_data  = 8'(base + j);
            in_eop   = eop_last && (j == len - 1);
            in_err   = err && in_eop;
            step();
        end
        idle_in();
    endtask

    task automatic read_pkt(input bit use_b, input int len, input int base, input string name);
        int bad;
        logic [8:0] exp;
        bad = 0;
        rd_req = 1'b1;
        for (int j = 0; j < len; j++) begin
            step();
            exp = {(j == len - 1), 8'(base + j)};
            if (use_b) begin
                if (!b_rd_valid || b_rd_data !== exp) bad++;
            end else begin
                if (!a_rd_valid || a_rd_data !== exp) bad++;
            end
        end
        rd_req = 1'b0;
        check(name, bad, 0);
    endtask

    initial begin
        int bad, reads;
        logic [8:0] q[$];
        logic [8:0] e;

        // Reset
        step(); step();
        @(negedge clk) rst_n = 1'b1;
        step();
        check("rst_rd_valid", a_rd_valid, 0);
        check("rst_rd_data", a_rd_data, 0);
        check("rst_empty", a_rd_empty, 1);
        check("rst_level", a_level, 0);
        check("rst_pkt", a_pkt, 0);
        check("rst_drop", a_drop, 0);
        check("rst_empty_b", b_rd_empty, 1);

        // Vector table on the 16-entry instance
        tbl[0]  = '{1'b1,1'b0,1'b0,8'hA1,1'b0, 1'b0,9'h000,5'd0,1'b1,16'd0,16'd0};
        tbl[1]  = '{1'b1,1'b0,1'b0,8'hA2,1'b0, 1'b0,9'h000,5'd0,1'b1,16'd0,16'd0};
        tbl[2]  = '{1'b1,1'b1,1'b0,8'hA3,1'b0, 1'b0,9'h000,5'd3,1'b0,16'd1,16'd0};
        tbl[3]  = '{1'b1,1'b1,1'b0,8'hB1,1'b1, 1'b1,9'h0A1,5'd3,1'b0,16'd2,16'd0};
        tbl[4]  = '{1'b1,1'b0,1'b0,8'hC1,1'b1, 1'b1,9'h0A2,5'd2,1'b0,16'd2,16'd0};
        tbl[5]  = '{1'b1,1'b1,1'b1,8'hC2,1'b1, 1'b1,9'h1A3,5'd1,1'b0,16'd2,16'd1};
        tbl[6]  = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,9'h1B1,5'd0,1'b1,16'd2,16'd1};
        tbl[7]  = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b0,9'h1B1,5'd0,1'b1,16'd2,16'd1};
        tbl[8]  = '{1'b1,1'b1,1'b1,8'hD1,1'b0, 1'b0,9'h1B1,5'd0,1'b1,16'd2,16'd2};
        tbl[9]  = '{1'b1,1'b0,1'b1,8'hE1,1'b0, 1'b0,9'h1B1,5'd0,1'b1,16'd2,16'd2};
        tbl[10] = '{1'b1,1'b1,1'b0,8'hE2,1'b0, 1'b0,9'h1B1,5'd2,1'b0,16'd3,16'd2};
        tbl[11] = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,9'h0E1,5'd1,1'b0,16'd3,16'd2};
        tbl[12] = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b1,9'h1E2,5'd0,1'b1,16'd3,16'd2};
        tbl[13] = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,9'h1E2,5'd0,1'b1,16'd3,16'd2};
        for (int i = 0; i < 14; i++) begin
            in_valid = tbl[i].v; in_eop = tbl[i].eop; in_err = tbl[i].err;
            in_data = tbl[i].d; rd_req = tbl[i].rd;
            step();
            check($sformatf("vec%0d_rd_valid", i), b_rd_valid, tbl[i].rv);
            check($sformatf("vec%0d_rd_data", i), b_rd_data, tbl[i].rdat);
            check($sformatf("vec%0d_level", i), b_level, tbl[i].lvl);
            check($sformatf("vec%0d_empty", i), b_rd_empty, tbl[i].emp);
            check($sformatf("vec%0d_pkt", i), b_pkt, tbl[i].pkt);
            check($sformatf("vec%0d_drop", i), b_drop, tbl[i].drop);
        end
        idle_in(); rd_req = 1'b0;

        // 64-byte good packet read back in one burst
        do_clear();
        send_pkt(64, 0, 1'b0, 1'b1);
        check("p64_level", a_level, 64);
        check("p64_pkt", a_pkt, 1);
        read_pkt(1'b0, 64, 0, "p64_data");
        check("p64_last_eop", a_rd_data[8], 1);
        check("p64_level_end", a_level, 0);
        check("p64_empty_end", a_rd_empty, 1);
        step();
        check("p64_valid_pulse", a_rd_valid, 0);

        // Errored packet dropped, following good packet intact
        do_clear();
        send_pkt(20, 8'h40, 1'b1, 1'b1);
        check("err_level", a_level, 0);
        check("err_drop", a_drop, 1);
        check("err_empty", a_rd_empty, 1);
        send_pkt(10, 8'h80, 1'b0, 1'b1);
        check("good_level", a_level, 10);
        check("good_pkt", a_pkt, 1);
        read_pkt(1'b0, 10, 8'h80, "good_data");

        // Overflow on 16 entries: second packet dropped, space after it still usable
        do_clear();
        send_pkt(10, 8'h10, 1'b0, 1'b1);
        check("ovf_level1", b_level, 10);
        send_pkt(9, 8'h20, 1'b0, 1'b0);
        check("ovf_drop_mid", b_drop, 0);
        send_pkt(1, 8'h29, 1'b0, 1'b1);
        check("ovf_drop", b_drop, 1);
        check("ovf_level2", b_level, 10);
        check("ovf_pkt", b_pkt, 1);
        send_pkt(6, 8'h30, 1'b0, 1'b1);
        check("ovf_fit6_level", b_level, 16);
        check("ovf_fit6_pkt", b_pkt, 2);
        read_pkt(1'b1, 10, 8'h10, "ovf_first_data");
        read_pkt(1'b1, 6, 8'h30, "ovf_fit6_data");
        check("ovf_empty", b_rd_empty, 1);

        // 3000 five-byte packets with concurrent draining
        do_clear();
        bad = 0; reads = 0;
        for (int p = 0; p < 3000; p++) begin
            for (int j = 0; j < 5; j++) begin
                in_valid = 1'b1;
                in_data  = 8'(p * 5 + j);
                in_eop   = (j == 4);
                q.push_back({in_eop, in_data});
                rd_req = !b_rd_empty;
                step();
                if (b_rd_valid) begin
                    reads++;
                    if (q.size() == 0) bad++;
                    else begin
                        e = q.pop_front();
                        if (b_rd_data !== e) bad++;
                    end
                end
            end
        end
        idle_in();
        for (int k = 0; k < 40; k++) begin
            rd_req = !b_rd_empty;
            step();
            if (b_rd_valid) begin
                reads++;
                if (q.size() == 0) bad++;
                else begin
                    e = q.pop_front();
                    if (b_rd_data !== e) bad++;
                end
            end
        end
        rd_req = 1'b0;
        check("wrap_reads", reads, 15000);
        check("wrap_data_bad", bad, 0);
        check("wrap_left", q.size(), 0);
        check("wrap_pkt", b_pkt, 3000);
        check("wrap_drop", b_drop, 0);
        check("wrap_pkt_sat", c_pkt, 7);

        // Drop counter saturation
        do_clear();
        for (int j = 0; j < 9; j++) send_pkt(1, j, 1'b1, 1'b1);
        check("sat_drop_c", c_drop, 7);
        check("sat_drop_b", b_drop, 9);

        // Clear mid-packet
        do_clear();
        send_pkt(30, 0, 1'b0, 1'b1);
        check("clr_level30", a_level, 30);
        send_pkt(3, 8'h50, 1'b0, 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'h53;
        step();
        clear = 1'b0; idle_in();
        check("clr_level", a_level, 0);
        check("clr_pkt", a_pkt, 0);
        check("clr_drop", a_drop, 0);
        check("clr_empty", a_rd_empty, 1);
        send_pkt(4, 8'h54, 1'b0, 1'b1);
        check("clr_tail_level", a_level, 0);
        check("clr_tail_pkt", a_pkt, 0);
        check("clr_tail_drop", a_drop, 0);
        send_pkt(2, 8'h60, 1'b0, 1'b1);
        check("clr_next_level", a_level, 2);
        check("clr_next_pkt", a_pkt, 1);
        read_pkt(1'b0, 2, 8'h60, "clr_next_data");

        // Asynchronous reset during a read burst
        do_clear();
        send_pkt(8, 8'h70, 1'b0, 1'b1);
        rd_req = 1'b1;
        step(); step(); step();
        check("arst_pre_valid", a_rd_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", a_rd_valid, 0);
        check("arst_data", a_rd_data, 0);
        check("arst_empty", a_rd_empty, 1);
        check("arst_level", a_level, 0);
        rd_req = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        check("arst_rel_empty", a_rd_empty, 1);
        check("arst_rel_level", a_level, 0);
        check("arst_rel_pkt", a_pkt, 0);
        check("arst_rel_valid", a_rd_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
